// File: rtl/mem_read_arbiter_pkg.sv
// Shared types and constants for the IC/DC memory read-channel arbiter.
package mem_read_arbiter_pkg;

  localparam int unsigned ADDR_WIDTH = 26;
  localparam int unsigned DATA_WIDTH = 32;
  localparam int unsigned LEN_WIDTH  = 4;
  localparam int unsigned ID_WIDTH   = 4;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_ADDR = 2'd1,
    ARB_DATA = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWNER_IC = 1'b0,
    OWNER_DC = 1'b1
  } arb_owner_e;

  localparam logic [ID_WIDTH-1:0] ARID_ICACHE = 4'd0;
  localparam logic [ID_WIDTH-1:0] ARID_DCACHE = 4'd1;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [LEN_WIDTH-1:0]  len;
  } ar_req_t;

  // A zero beat count is treated as a single-beat burst.
  function automatic logic [LEN_WIDTH-1:0] norm_len(input logic [LEN_WIDTH-1:0] len);
    return (len == '0) ? LEN_WIDTH'(1) : len;
  endfunction

  function automatic logic [ID_WIDTH-1:0] owner_id(input arb_owner_e owner);
    return (owner == OWNER_DC) ? ARID_DCACHE : ARID_ICACHE;
  endfunction

endpackage

// File: rtl/mem_read_arbiter_if.sv
// Cache-side and memory-side read channel signals bundled for the arbiter.
interface mem_read_arbiter_if;
  import mem_read_arbiter_pkg::*;

  logic                  ic_arvalid;
  logic [ADDR_WIDTH-1:0] ic_araddr;
  logic [LEN_WIDTH-1:0]  ic_arlen;
  logic                  ic_arready;
  logic                  ic_rvalid;
  logic                  dc_arvalid;
  logic [ADDR_WIDTH-1:0] dc_araddr;
  logic [LEN_WIDTH-1:0]  dc_arlen;
  logic                  dc_arready;
  logic                  dc_rvalid;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  mem_arvalid;
  logic [ADDR_WIDTH-1:0] mem_araddr;
  logic [LEN_WIDTH-1:0]  mem_arlen;
  logic [ID_WIDTH-1:0]   mem_arid;
  logic                  mem_arready;
  logic                  mem_rvalid;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  mem_rready;
  logic                  err_stray_r;

  // Arbiter view: serves the caches and masters the memory channel.
  modport slave (
    input  ic_arvalid, ic_araddr, ic_arlen,
    input  dc_arvalid, dc_araddr, dc_arlen,
    input  mem_arready, mem_rvalid, mem_rdata,
    output ic_arready, ic_rvalid, dc_arready, dc_rvalid, r_data,
    output mem_arvalid, mem_araddr, mem_arlen, mem_arid, mem_rready,
    output err_stray_r
  );

  // Environment view: the two caches plus the memory controller.
  modport master (
    output ic_arvalid, ic_araddr, ic_arlen,
    output dc_arvalid, dc_araddr, dc_arlen,
    output mem_arready, mem_rvalid, mem_rdata,
    input  ic_arready, ic_rvalid, dc_arready, dc_rvalid, r_data,
    input  mem_arvalid, mem_araddr, mem_arlen, mem_arid, mem_rready,
    input  err_stray_r
  );

endinterface

// File: rtl/mem_read_arbiter_rr_arbiter2.sv
// Two-input round-robin picker; remembers the last served requester.
module rr_arbiter2
  import mem_read_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_ic_i,
  input  logic       req_dc_i,
  input  logic       grant_en_i,
  input  logic       update_i,
  input  arb_owner_e update_owner_i,
  output logic       gnt_valid_o,
  output arb_owner_e gnt_owner_o
);

  arb_owner_e last_q;
  arb_owner_e last_d;

  // Reset to IC so that DC wins the first tie.
  always_ff @(posedge clk) begin
    if (!rst_n) last_q <= OWNER_IC;
    else        last_q <= last_d;
  end

  assign last_d = update_i ? update_owner_i : last_q;

  always_comb begin
    gnt_valid_o = grant_en_i && (req_ic_i || req_dc_i);
    gnt_owner_o = OWNER_IC;
    if (req_ic_i && req_dc_i) gnt_owner_o = (last_q == OWNER_IC) ? OWNER_DC : OWNER_IC;
    else if (req_dc_i)        gnt_owner_o = OWNER_DC;
  end

endmodule

// File: rtl/mem_read_arbiter.sv
// Shares one memory read channel between IC and DC, one burst outstanding at a time.
module mem_read_arbiter
  import mem_read_arbiter_pkg::*;
(
  input logic               clk,
  input logic               rst_n,
  mem_read_arbiter_if.slave bus
);

  arb_state_e           state_q, state_d;
  arb_owner_e           owner_q, owner_d;
  ar_req_t              req_q, req_d;
  logic [LEN_WIDTH-1:0] beat_q, beat_d;
  logic                 err_q, err_d;

  logic       gnt_valid;
  arb_owner_e gnt_owner;
  logic       burst_done;

  rr_arbiter2 u_rr (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_ic_i       (bus.ic_arvalid),
    .req_dc_i       (bus.dc_arvalid),
    .grant_en_i     (state_q == ARB_IDLE),
    .update_i       (burst_done),
    .update_owner_i (owner_q),
    .gnt_valid_o    (gnt_valid),
    .gnt_owner_o    (gnt_owner)
  );

  assign burst_done = (state_q == ARB_DATA) && bus.mem_rvalid
                      && (beat_q == (req_q.len - LEN_WIDTH'(1)));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ARB_IDLE;
      owner_q <= OWNER_IC;
      req_q   <= '0;
      beat_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      req_q   <= req_d;
      beat_q  <= beat_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    req_d   = req_q;
    beat_d  = beat_q;
    // Any beat outside a data phase belongs to nobody and is flagged.
    err_d   = err_q || (bus.mem_rvalid && (state_q != ARB_DATA));

    bus.ic_arready  = 1'b0;
    bus.dc_arready  = 1'b0;
    bus.ic_rvalid   = 1'b0;
    bus.dc_rvalid   = 1'b0;
    bus.mem_arvalid = 1'b0;
    bus.mem_araddr  = req_q.addr;
    bus.mem_arlen   = req_q.len;
    bus.mem_arid    = owner_id(owner_q);
    bus.mem_rready  = 1'b1;
    bus.r_data      = bus.mem_rdata;
    bus.err_stray_r = err_q;

    unique case (state_q)
      ARB_IDLE: begin
        if (gnt_valid) begin
          owner_d = gnt_owner;
          if (gnt_owner == OWNER_DC) begin
            req_d.addr = bus.dc_araddr;
            req_d.len  = norm_len(bus.dc_arlen);
          end else begin
            req_d.addr = bus.ic_araddr;
            req_d.len  = norm_len(bus.ic_arlen);
          end
          state_d = ARB_ADDR;
        end
      end
      ARB_ADDR: begin
        bus.mem_arvalid = 1'b1;
        bus.ic_arready  = (owner_q == OWNER_IC) && bus.mem_arready;
        bus.dc_arready  = (owner_q == OWNER_DC) && bus.mem_arready;
        if (bus.mem_arready) begin
          state_d = ARB_DATA;
          beat_d  = '0;
        end
      end
      ARB_DATA: begin
        bus.ic_rvalid = (owner_q == OWNER_IC) && bus.mem_rvalid;
        bus.dc_rvalid = (owner_q == OWNER_DC) && bus.mem_rvalid;
        if (burst_done) begin
          state_d = ARB_IDLE;
          beat_d  = '0;
        end else if (bus.mem_rvalid) begin
          beat_d = beat_q + LEN_WIDTH'(1);
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

endmodule

// File: doc/mem_read_arbiter.md
Name: mem_read_arbiter

Overview:
- Shares the single memory read-address/read-data channel between the instruction cache (requester IC) and the data cache (requester DC).
- Serialises refill bursts. One burst is outstanding at a time. Each R beat is routed to the requester that owns the current burst.
- Sits between both caches' read ports and the memory-side AXI-style read channel. The write channels bypass this block; DC is the only writer.

Parameters:
ADDR_WIDTH, `ADDR_WIDTH (26), byte address width
DATA_WIDTH, `DATA_WIDTH (32), read data width
LEN_WIDTH, 4, burst length field width; value = number of beats (1..8 legal)

Ports:
clk  in  1  clock
rst_n  in  1  synchronous reset, active low
ic_arvalid  in  1  IC read request; held until ic_arready
ic_araddr  in  ADDR_WIDTH  IC line address
ic_arlen  in  LEN_WIDTH  IC beat count
ic_arready  out  1  IC address accepted by memory
ic_rvalid  out  1  beat for IC
dc_arvalid  in  1  DC read request; held until dc_arready
dc_araddr  in  ADDR_WIDTH  DC line address
dc_arlen  in  LEN_WIDTH  DC beat count
dc_arready  out  1  DC address accepted by memory
dc_rvalid  out  1  beat for DC
r_data  out  DATA_WIDTH  mem_rdata, broadcast to both requesters
mem_arvalid  out  1  address valid to memory
mem_araddr  out  ADDR_WIDTH  latched owner address
mem_arlen  out  LEN_WIDTH  latched owner length
mem_arid  out  4  0 = IC, 1 = DC
mem_arready  in  1  memory accepts address
mem_rvalid  in  1  memory beat valid
mem_rdata  in  DATA_WIDTH  memory beat data
mem_rready  out  1  constant 1
err_stray_r  out  1  sticky: mem_rvalid seen with no burst in DATA

Behaviour:
- Interface: one clock (clk); synchronous active-low reset rst_n.
- Reset values:
  - state = ARB_IDLE; owner = IC; last_grant = IC, so DC wins the first tie.
  - beat_cnt = 0; err_stray_r = 0.
  - mem_arvalid, ic/dc_arready and ic/dc_rvalid = 0.
  - mem_rready = 1 always.
- ARB_IDLE:
  - Arbitration happens only in this state.
  - Only one requester valid: that requester is granted.
  - Both valid: the requester not equal to last_grant is granted (round robin).
  - On grant: latch owner, addr and len (len 0 is latched as 1); next state ARB_ADDR.
  - No request: stay.
- ARB_ADDR:
  - mem_arvalid = 1 with latched fields; mem_arid = owner.
  - Requester arready = mem_arready, asserted only to the owner, combinational in the same cycle.
  - On mem_arready: next state ARB_DATA, beat_cnt = 0.
  - Requester-side arvalid changes in this state are ignored, because fields are latched.
- ARB_DATA:
  - Owner's rvalid = mem_rvalid, combinational and zero latency. The other requester's rvalid = 0.
  - Each mem_rvalid increments beat_cnt.
  - When mem_rvalid and beat_cnt == len-1: next state ARB_IDLE, last_grant = owner, beat_cnt = 0.
- Latency:
  - Request in IDLE at cycle N gives mem_arvalid at N+1.
  - Minimum gap between bursts is one IDLE cycle, in which the new grant is made.
- Fairness: under continuous requests from both sides, grants alternate IC/DC. Neither requester waits more than one foreign burst.
- Stray beats:
  - mem_rvalid in IDLE/ADDR is dropped, forwarded to nobody, and sets err_stray_r.
  - err_stray_r clears only on reset.
- Reset mid-operation:
  - Any state returns to IDLE next cycle; latched fields are discarded.
  - Beats still arriving after reset are strays and set the flag. This is accepted behaviour.
- Requester obligations (not checked): hold arvalid until arready; accept every rvalid beat. There is no backpressure on R.

Decomposition:
- mips_core_pkg gets ArbState enum (ARB_IDLE, ARB_ADDR, ARB_DATA), ArbOwner enum (OWNER_IC = 0, OWNER_DC = 1) and constants ARID_ICACHE = 4'd0, ARID_DCACHE = 4'd1.
- One natural sub-module: rr_arbiter2. It is a 2-input round-robin picker holding last_grant, with grant_en/update strobes, and is reusable for a future write-channel arbiter.

Test Plan:
- Only DC requests, addr 0x0000100, len 4, mem_arready on 2nd ADDR cycle, 4 beats 0xA..0xD -> mem_arid = 1; dc_rvalid pulses 4×, data 0xA..0xD; ic_rvalid stays 0; back in IDLE after 4th beat.
- Both request in the same cycle after reset -> DC is granted first; IC is granted in the IDLE cycle after DC's last beat; mem_arid sequence 1, 0.
- Both request continuously for 6 bursts, len 2 -> grant order DC, IC, DC, IC, DC, IC; no requester starves.
- mem_rvalid pulses while IDLE -> no rvalid to either requester; err_stray_r = 1 and stays 1 until rst_n = 0.
- rst_n low for 1 cycle during ARB_DATA after beat 2 of 4 -> IDLE next cycle, beat_cnt = 0; remaining beats set err_stray_r; a new IC request is then granted normally.
- IC request with len 0 -> mem_arlen = 1; burst ends after a single beat.
